// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and decode helper for the fetch stage.
//   - default widths for PC/address and instruction
//   - opcode and condition-code encodings, instruction field positions
//   - decode_kind(): classifies a raw instruction for the next-PC mux
package fetch_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int INSTR_W_DEF = 19;

  localparam logic [2:0] OP_BRANCH = 3'b101;
  localparam logic [4:0] OP_JMP    = 5'b11100;
  localparam logic [4:0] OP_JSB    = 5'b11101;
  localparam logic [4:0] OP_RET    = 5'b11110;

  localparam logic [1:0] COND_Z  = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_C  = 2'b10;
  localparam logic [1:0] COND_NC = 2'b11;

  // Field positions inside the instruction word
  localparam int OP_MSB   = 18;
  localparam int OP3_LSB  = 16;
  localparam int OP5_LSB  = 14;
  localparam int COND_MSB = 15;
  localparam int COND_LSB = 14;
  localparam int OFF_MSB  = 7;
  localparam int OFF_LSB  = 0;
  localparam int TGT_MSB  = 11;
  localparam int TGT_LSB  = 0;

  typedef enum logic [2:0] {
    KIND_SEQ,
    KIND_BRANCH,
    KIND_JMP,
    KIND_JSB,
    KIND_RET
  } kind_e;

  function automatic kind_e decode_kind(input logic [OP_MSB:OP5_LSB] op);
    kind_e k;
    k = KIND_SEQ;
    if (op[OP_MSB:OP3_LSB] == OP_BRANCH) k = KIND_BRANCH;
    else if (op == OP_JMP)               k = KIND_JMP;
    else if (op == OP_JSB)               k = KIND_JSB;
    else if (op == OP_RET)               k = KIND_RET;
    return k;
  endfunction

endpackage

// File: rtl/fetch_unit_return_stack.sv
// return_stack: DEPTH x W LIFO holding subroutine return addresses.
//   clock, reset : clock, async active-high reset (empties the stack)
//   push, din    : push din when not full (dropped when full)
//   pop          : drop the top entry when not empty
//   dout         : current top entry (meaningless while empty)
//   full, empty  : occupancy status
// push and pop are never asserted together by the fetch unit.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // count_q is one bit wider than an index so full and empty are distinct
  logic [PTR_W:0]   count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;

  assign wr_idx  = count_q[PTR_W-1:0];
  assign top_idx = wr_idx - PTR_W'(1);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    if (push && !full)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !empty) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Storage needs no reset: entries are only read below the pointer
  always_ff @(posedge clock) begin
    if (push && !full) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction register and local redirect
// resolution (branches, JMP, JSB, RET) with a return-address stack.
//   clock, reset          : clock, async active-high reset
//   stall                 : freeze PC, IR, stack and flags
//   instr_in              : instruction at pc_out (combinational memory read)
//   zero_flag, carry_flag : registered flags from execute
//   pc_out                : fetch address (pure register output)
//   ir_out, ir_pc         : latched instruction and its address
//   ir_valid              : ir_out holds a fetched instruction
//   stack_overflow        : sticky, JSB with a full stack
//   stack_underflow       : sticky, RET with an empty stack
// Handshake: ir_valid is the valid of the decode interface and stall is the
// inverse of its ready; an instruction advances only on an edge where
// ir_valid=1 and stall=0, and nothing changes on an edge with stall=1.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int INSTR_W     = INSTR_W_DEF,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               zero_flag,
  input  logic               carry_flag,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               stack_overflow,
  output logic               stack_underflow
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;

  kind_e              kind;
  logic [1:0]         cond;
  logic               taken;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  off_sext;
  logic [ADDR_W-1:0]  target;
  logic               push, pop;
  logic [ADDR_W-1:0]  stack_top;
  logic               stack_full, stack_empty;
  logic               unused_bits;

  assign kind        = decode_kind(instr_in[OP_MSB:OP5_LSB]);
  assign cond        = instr_in[COND_MSB:COND_LSB];
  assign target      = instr_in[TGT_MSB:TGT_LSB];
  assign off_sext    = {{(ADDR_W-8){instr_in[OFF_MSB]}}, instr_in[OFF_MSB:OFF_LSB]};
  assign pc_inc      = pc_q + ADDR_W'(1);
  assign unused_bits = ^instr_in[13:12];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_Z:  taken = zero_flag;
      COND_NZ: taken = !zero_flag;
      COND_C:  taken = carry_flag;
      COND_NC: taken = !carry_flag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d       = pc_inc;
    ir_d       = instr_in;
    ir_pc_d    = pc_q;
    ir_valid_d = 1'b1;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    push       = 1'b0;
    pop        = 1'b0;

    case (kind)
      KIND_BRANCH: if (taken) pc_d = pc_inc + off_sext;
      KIND_JMP:    pc_d = target;
      KIND_JSB: begin
        // The jump is taken even when the return address cannot be saved
        pc_d = target;
        if (stack_full) ovf_d = 1'b1;
        else            push  = 1'b1;
      end
      KIND_RET: begin
        // RET on an empty stack falls through like a NOP
        if (stack_empty) udf_d = 1'b1;
        else begin
          pc_d = stack_top;
          pop  = 1'b1;
        end
      end
      default: ;
    endcase

    if (stall) begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      push       = 1'b0;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stack_top),
    .full  (stack_full),
    .empty (stack_empty)
  );

  assign pc_out          = pc_q;
  assign ir_out          = ir_q;
  assign ir_pc           = ir_pc_q;
  assign ir_valid        = ir_valid_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = udf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural instruction memory,
// directed programs, a scoreboard queue of expected {ir_pc, ir_out, pc_out}
// tuples filled by the driver and drained by a negedge monitor.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [18:0] instr_in;
  logic        zero_flag;
  logic        carry_flag;
  logic [11:0] pc_out;
  logic [18:0] ir_out;
  logic        ir_valid;
  logic [11:0] ir_pc;
  logic        stack_overflow;
  logic        stack_underflow;

  logic [18:0] mem [4096];
  logic [42:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  assign instr_in = mem[pc_out];

  fetch_unit dut (
    .clock           (clk),
    .reset           (reset),
    .stall           (stall),
    .instr_in        (instr_in),
    .zero_flag       (zero_flag),
    .carry_flag      (carry_flag),
    .pc_out          (pc_out),
    .ir_out          (ir_out),
    .ir_valid        (ir_valid),
    .ir_pc           (ir_pc),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- encoders ----------------
  function automatic logic [18:0] fil(input int a);
    logic [11:0] a12;
    a12 = a[11:0];
    return {3'b001, 4'b0000, a12};
  endfunction
  function automatic logic [18:0] br(input logic [1:0] c, input logic [7:0] off);
    return {3'b101, c, 6'b000000, off};
  endfunction
  function automatic logic [18:0] jmp(input logic [11:0] t);
    return {5'b11100, 2'b00, t};
  endfunction
  function automatic logic [18:0] jsb(input logic [11:0] t);
    return {5'b11101, 2'b00, t};
  endfunction
  function automatic logic [18:0] ret();
    return {5'b11110, 14'd0};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic expect_fetch(input int ipc, input logic [18:0] ir, input int npc);
    logic [11:0] a;
    logic [11:0] b;
    a = ipc[11:0];
    b = npc[11:0];
    exp_q.push_back({a, ir, b});
  endtask

  // Monitor: every presented instruction is compared against the queue head
  always @(negedge clk) begin
    logic [42:0] e;
    if (!reset && ir_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({ir_pc, ir_out, pc_out} === e) n_pass++;
      else $display("FAIL fetch: got ir_pc=%0d ir=%05h pc=%0d expected ir_pc=%0d ir=%05h pc=%0d",
                    ir_pc, ir_out, pc_out, e[42:31], e[30:12], e[11:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic begin_test();
    reset = 1'b1;
    stall = 1'b0;
    exp_q.delete();
    for (int a = 0; a < 4096; a++) mem[a] = fil(a);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    zero_flag  = 1'b0;
    carry_flag = 1'b0;

    // Reset state and sequential fetch
    begin_test();
    #2;
    check("rst_pc", pc_out, 0);
    check("rst_ir", ir_out, 0);
    check("rst_ir_pc", ir_pc, 0);
    check("rst_valid", ir_valid, 0);
    check("rst_ovf", stack_overflow, 0);
    check("rst_udf", stack_underflow, 0);
    for (int i = 0; i < 4; i++) expect_fetch(i, fil(i), i + 1);
    release_reset();
    check("rel_valid_low", ir_valid, 0);
    check("rel_pc0", pc_out, 0);
    wait_drain("seq");

    // BZ +3 taken, BZ not taken, BNC -2 taken
    for (int t = 0; t < 3; t++) begin
      begin_test();
      if (t < 2) mem[5] = br(2'b00, 8'd3);
      else       mem[5] = br(2'b11, 8'hFE);
      zero_flag  = (t == 0);
      carry_flag = 1'b0;
      for (int i = 0; i < 5; i++) expect_fetch(i, fil(i), i + 1);
      if (t == 0) begin
        expect_fetch(5, mem[5], 9);
        expect_fetch(9, fil(9), 10);
      end else if (t == 1) begin
        expect_fetch(5, mem[5], 6);
        expect_fetch(6, fil(6), 7);
      end else begin
        expect_fetch(5, mem[5], 4);
        expect_fetch(4, fil(4), 5);
      end
      release_reset();
      wait_drain("branch");
    end
    zero_flag = 1'b0;

    // JSB / RET round trip
    begin_test();
    mem[2]   = jsb(12'd100);
    mem[100] = ret();
    expect_fetch(0, fil(0), 1);
    expect_fetch(1, fil(1), 2);
    expect_fetch(2, mem[2], 100);
    expect_fetch(100, mem[100], 3);
    expect_fetch(3, fil(3), 4);
    release_reset();
    wait_drain("call");
    check("call_empty", {31'd0, dut.u_stack.empty}, 1);
    check("call_ovf", stack_overflow, 0);
    check("call_udf", stack_underflow, 0);

    // Nine nested JSB: the ninth push is dropped, RET returns to 71
    begin_test();
    for (int i = 0; i < 9; i++) mem[i*10] = jsb(12'(i*10 + 10));
    mem[90] = ret();
    for (int i = 0; i < 9; i++) expect_fetch(i*10, mem[i*10], i*10 + 10);
    expect_fetch(90, mem[90], 71);
    expect_fetch(71, fil(71), 72);
    release_reset();
    wait_drain("nest");
    check("nest_ovf", stack_overflow, 1);
    check("nest_udf", stack_underflow, 0);

    // RET on empty stack at 20 acts as NOP
    begin_test();
    mem[20] = ret();
    for (int i = 0; i < 20; i++) expect_fetch(i, fil(i), i + 1);
    expect_fetch(20, mem[20], 21);
    expect_fetch(21, fil(21), 22);
    release_reset();
    wait_drain("udf");
    check("udf_flag", stack_underflow, 1);
    check("udf_ovf", stack_overflow, 0);

    // Stall for 3 cycles with a JSB waiting at pc 7
    begin_test();
    mem[7]  = jsb(12'd50);
    mem[50] = ret();
    for (int i = 0; i < 7; i++) expect_fetch(i, fil(i), i + 1);
    for (int i = 0; i < 3; i++) expect_fetch(6, fil(6), 7);
    expect_fetch(7, mem[7], 50);
    expect_fetch(50, mem[50], 8);
    expect_fetch(8, fil(8), 9);
    release_reset();
    begin
      int k;
      k = 0;
      while (pc_out !== 12'd7 && k < 50) begin
        @(negedge clk);
        #1;
        k++;
      end
      check("stall_reach_pc7", pc_out, 7);
    end
    stall = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 stall = 1'b0;
    wait_drain("stall");
    check("stall_empty", {31'd0, dut.u_stack.empty}, 1);
    check("stall_ovf", stack_overflow, 0);

    // JMP 4095 then wrap to 0; async reset during stall
    begin_test();
    mem[0] = jmp(12'd4095);
    expect_fetch(0, mem[0], 4095);
    expect_fetch(4095, fil(4095), 0);
    expect_fetch(0, mem[0], 4095);
    release_reset();
    wait_drain("wrap");
    stall = 1'b1;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_pc", pc_out, 0);
    check("async_ir", ir_out, 0);
    check("async_ir_pc", ir_pc, 0);
    check("async_valid", ir_valid, 0);
    check("async_ovf", stack_overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
